// File: rtl/vga_ctrl.sv
// VGA timing generator and pixel fetcher.
// Free-running h/v counters drive the frame-buffer address combinationally; the returned
// pixel and the sync/blank flags are registered together so all pins share one clock of lag.
module vga_ctrl #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        addr_valid,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int unsigned HTotal = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned VTotal = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW     = $clog2(HTotal);
    localparam int unsigned VW     = $clog2(VTotal);

    localparam logic [HW-1:0] HMax      = HW'(HTotal - 1);
    localparam logic [VW-1:0] VMax      = VW'(VTotal - 1);
    localparam logic [HW-1:0] HSyncEnd  = HW'(H_SYNC);
    localparam logic [VW-1:0] VSyncEnd  = VW'(V_SYNC);
    localparam logic [HW-1:0] HActStart = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] HActEnd   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] VActStart = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] VActEnd   = VW'(V_SYNC + V_BP + V_ACTIVE);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_active, v_active;

    logic          hsync_q, vsync_q, blank_n_q, frame_start_q;
    logic [23:0]   rgb_q;

    // Next counter position: h wraps every line, v advances at end of each line.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HMax) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VMax) ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Counter registers, reset to the top-left of the sync region.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Address stage: window decode and pixel coordinates, zero outside the window.
    always_comb begin
        h_active   = (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd);
        v_active   = (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);
        addr_valid = h_active && v_active;
        h_addr     = '0;
        v_addr     = '0;
        if (addr_valid) begin
            h_addr = 10'(h_cnt_q - HActStart);
            v_addr = 10'(v_cnt_q - VActStart);
        end
    end

    // Output stage: one register level so sync, blank and RGB stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= !(h_cnt_q < HSyncEnd);
            vsync_q       <= !(v_cnt_q < VSyncEnd);
            blank_n_q     <= addr_valid;
            rgb_q         <= addr_valid ? vga_data : 24'h0;
            frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    // Pin breakout.
    always_comb begin
        hsync       = hsync_q;
        vsync       = vsync_q;
        blank_n     = blank_n_q;
        frame_start = frame_start_q;
        vga_r       = rgb_q[23:16];
        vga_g       = rgb_q[15:8];
        vga_b       = rgb_q[7:0];
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl using scaled-down timing so whole frames fit the run.
// Expected values come from the cycle count since reset: position = count mod line/frame.
module tb_vga_ctrl;

    localparam int unsigned H_SYNC   = 12;
    localparam int unsigned H_BP     = 8;
    localparam int unsigned H_ACTIVE = 40;
    localparam int unsigned H_FP     = 6;
    localparam int unsigned V_SYNC   = 3;
    localparam int unsigned V_BP     = 4;
    localparam int unsigned V_ACTIVE = 12;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned HT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned VT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned FR  = HT * VT;
    localparam int unsigned HA0 = H_SYNC + H_BP;
    localparam int unsigned VA0 = V_SYNC + V_BP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] vga_data;
    logic [9:0]  h_addr, v_addr;
    logic        addr_valid, hsync, vsync, blank_n, frame_start;
    logic [7:0]  vga_r, vga_g, vga_b;

    int checks   = 0;
    int failures = 0;
    int unsigned k = 0;      // clock edges since the last reset edge
    logic [7:0]  salt = 8'hA5;
    logic        garble = 1'b0;
    logic [23:0] noise = 24'hFFFFFF;

    vga_ctrl #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP)
    ) dut (
        .clk(clk), .rst(rst), .vga_data(vga_data),
        .h_addr(h_addr), .v_addr(v_addr), .addr_valid(addr_valid),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame-buffer stand-in; optionally garbage while blanking.
    always_comb begin
        vga_data = {h_addr[7:0], v_addr[7:0], salt};
        if (garble && !addr_valid) vga_data = noise;
    end

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Reference model: position p counts edges since reset.
    function automatic int unsigned mh(int unsigned p); return p % HT; endfunction
    function automatic int unsigned mv(int unsigned p); return (p / HT) % VT; endfunction
    function automatic bit mvalid(int unsigned p);
        return mh(p) >= HA0 && mh(p) < HA0 + H_ACTIVE && mv(p) >= VA0 && mv(p) < VA0 + V_ACTIVE;
    endfunction
    function automatic logic [9:0] mhaddr(int unsigned p);
        return mvalid(p) ? 10'(mh(p) - HA0) : 10'd0;
    endfunction
    function automatic logic [9:0] mvaddr(int unsigned p);
        return mvalid(p) ? 10'(mv(p) - VA0) : 10'd0;
    endfunction
    // Pin values after the k-th edge (k==0 means the reset edge).
    function automatic logic [23:0] mrgb(int unsigned kk);
        logic [9:0] ha, va;
        if (kk == 0 || !mvalid(kk - 1)) return 24'h0;
        ha = mhaddr(kk - 1);
        va = mvaddr(kk - 1);
        return {ha[7:0], va[7:0], salt};
    endfunction
    function automatic logic mhs(int unsigned kk);
        return (kk == 0) ? 1'b1 : !(mh(kk - 1) < H_SYNC);
    endfunction
    function automatic logic mvs(int unsigned kk);
        return (kk == 0) ? 1'b1 : !(mv(kk - 1) < V_SYNC);
    endfunction
    function automatic logic mblank(int unsigned kk);
        return (kk == 0) ? 1'b0 : mvalid(kk - 1);
    endfunction
    function automatic logic mfs(int unsigned kk);
        return (kk == 0) ? 1'b0 : (mh(kk - 1) == 0 && mv(kk - 1) == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) step();
        checks++;
        if ({hsync, vsync, blank_n, frame_start, addr_valid} !== 5'b11000 ||
            {vga_r, vga_g, vga_b} !== 24'h0 || h_addr !== 10'd0 || v_addr !== 10'd0) begin
            failures++;
            $display("FAIL reset_values: hs=%b vs=%b bn=%b fs=%b av=%b rgb=%h ha=%0d va=%0d, want 1 1 0 0 0 0 0 0",
                     hsync, vsync, blank_n, frame_start, addr_valid, {vga_r, vga_g, vga_b},
                     h_addr, v_addr);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({hsync, vsync, frame_start} !== 3'b001) begin
            failures++;
            $display("FAIL first_edge: hs/vs/fs=%b, want 001", {hsync, vsync, frame_start});
        end
        step();
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL second_edge_fs: got %b want 0", frame_start);
        end
    endtask

    task automatic test_line_timing();
        int n, hi, lo;
        do_reset(2);
        step();
        n = 0;
        while (hsync !== 1'b1 && n < 2 * HT) begin step(); n++; end
        checks++;
        if (k != H_SYNC + 1) begin
            failures++;
            $display("FAIL hsync_first_low: rose at edge %0d, want %0d", k, H_SYNC + 1);
        end
        for (int line = 0; line < 3; line++) begin
            hi = 0;
            while (hsync === 1'b1 && hi < 2 * HT) begin step(); hi++; end
            lo = 0;
            while (hsync === 1'b0 && lo < 2 * HT) begin step(); lo++; end
            checks++;
            if (hi != HT - H_SYNC || lo != H_SYNC || hi + lo != HT) begin
                failures++;
                $display("FAIL hsync_line%0d: high=%0d low=%0d, want high=%0d low=%0d",
                         line, hi, lo, HT - H_SYNC, H_SYNC);
            end
        end
    endtask

    task automatic test_active_window();
        int unsigned t0;
        do_reset(2);
        t0 = VA0 * HT + HA0;
        while (k < t0) step();
        checks++;
        if (h_addr !== 10'd0 || v_addr !== 10'd0 || addr_valid !== 1'b1 || blank_n !== 1'b0) begin
            failures++;
            $display("FAIL window_start: ha=%0d va=%0d av=%b bn=%b, want 0 0 1 0",
                     h_addr, v_addr, addr_valid, blank_n);
        end
        step();
        checks++;
        if (blank_n !== 1'b1) begin
            failures++;
            $display("FAIL blank_rise: bn=%b want 1", blank_n);
        end
        while (k < t0 + H_ACTIVE - 1) step();
        checks++;
        if (h_addr !== 10'(H_ACTIVE - 1) || addr_valid !== 1'b1) begin
            failures++;
            $display("FAIL window_last: ha=%0d av=%b, want %0d 1", h_addr, addr_valid, H_ACTIVE - 1);
        end
        step();
        checks++;
        if (addr_valid !== 1'b0 || h_addr !== 10'd0 || blank_n !== 1'b1) begin
            failures++;
            $display("FAIL window_end: av=%b ha=%0d bn=%b, want 0 0 1", addr_valid, h_addr, blank_n);
        end
        step();
        checks++;
        if (blank_n !== 1'b0) begin
            failures++;
            $display("FAIL blank_fall: bn=%b want 0", blank_n);
        end
    endtask

    task automatic test_data_path(input bit dirty);
        salt   = 8'($urandom);
        garble = dirty;
        do_reset(3);
        for (int i = 0; i < int'(FR) + 2; i++) begin
            noise = (i == 0) ? 24'hFFFFFF : 24'($urandom);
            step();
            checks++;
            if (h_addr !== mhaddr(k) || v_addr !== mvaddr(k) || addr_valid !== mvalid(k) ||
                {vga_r, vga_g, vga_b} !== mrgb(k) || hsync !== mhs(k) || vsync !== mvs(k) ||
                blank_n !== mblank(k) || frame_start !== mfs(k)) begin
                failures++;
                $display("FAIL data_path k=%0d: ha=%0d va=%0d av=%b rgb=%h hs=%b vs=%b bn=%b fs=%b, want %0d %0d %b %h %b %b %b %b",
                         k, h_addr, v_addr, addr_valid, {vga_r, vga_g, vga_b}, hsync, vsync,
                         blank_n, frame_start, mhaddr(k), mvaddr(k), mvalid(k), mrgb(k),
                         mhs(k), mvs(k), mblank(k), mfs(k));
            end
        end
        garble = 1'b0;
    endtask

    task automatic test_frame_timing();
        int unsigned n, m;
        do_reset(2);
        step();
        checks++;
        if (frame_start !== 1'b1 || vsync !== 1'b0) begin
            failures++;
            $display("FAIL frame_first: fs=%b vs=%b, want 1 0", frame_start, vsync);
        end
        n = 0;
        while (vsync === 1'b0 && n < 2 * FR) begin step(); n++; end
        checks++;
        if (n != V_SYNC * HT) begin
            failures++;
            $display("FAIL vsync_low: %0d clocks, want %0d", n, V_SYNC * HT);
        end
        m = n;
        while (frame_start !== 1'b1 && m < 2 * FR) begin step(); m++; end
        checks++;
        if (m != FR) begin
            failures++;
            $display("FAIL frame_period1: %0d clocks, want %0d", m, FR);
        end
        m = 0;
        step(); m++;
        while (frame_start !== 1'b1 && m < 2 * FR) begin step(); m++; end
        checks++;
        if (m != FR) begin
            failures++;
            $display("FAIL frame_period2: %0d clocks, want %0d", m, FR);
        end
    endtask

    task automatic test_mid_reset(input int unsigned rv, input int unsigned rh);
        int unsigned target;
        do_reset(2);
        target = rv * HT + rh + 1;
        while (k < target) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({hsync, vsync, blank_n, frame_start, addr_valid} !== 5'b11000 ||
            {vga_r, vga_g, vga_b} !== 24'h0 || h_addr !== 10'd0 || v_addr !== 10'd0) begin
            failures++;
            $display("FAIL mid_reset_values (v=%0d h=%0d): hs=%b vs=%b bn=%b fs=%b av=%b rgb=%h",
                     rv, rh, hsync, vsync, blank_n, frame_start, addr_valid,
                     {vga_r, vga_g, vga_b});
        end
        for (int i = 0; i < int'(FR) + 1; i++) begin
            step();
            checks++;
            if (frame_start !== mfs(k) || hsync !== mhs(k) || vsync !== mvs(k) ||
                blank_n !== mblank(k) || {vga_r, vga_g, vga_b} !== mrgb(k)) begin
                failures++;
                $display("FAIL mid_reset_frame k=%0d: fs=%b hs=%b vs=%b bn=%b rgb=%h, want %b %b %b %b %h",
                         k, frame_start, hsync, vsync, blank_n, {vga_r, vga_g, vga_b},
                         mfs(k), mhs(k), mvs(k), mblank(k), mrgb(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_active_window();
        test_data_path(1'b0);
        test_data_path(1'b1);
        test_frame_timing();
        test_mid_reset(VA0 + V_ACTIVE / 2, HA0 + H_ACTIVE / 3);
        test_mid_reset($urandom_range(VT - 1, 0), $urandom_range(HT - 1, 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
